// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: stalls the front end on hazards the forwarding unit cannot cover
// and flushes IF/ID on taken branches. Define STALL_COUNTER_EN for saturating event counters.
module hazard_stall_unit #(
  parameter int REG_W = 5
`ifdef STALL_COUNTER_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic             clk__i,
  input  logic             reset__i,
  input  logic [REG_W-1:0] IFID_RegRs__i,
  input  logic [REG_W-1:0] IFID_RegRt__i,
  input  logic             IFID_UsesRt__i,
  input  logic             Branch__i,
  input  logic             BranchTaken__i,
  input  logic             IDEX_MemRead__i,
  input  logic             IDEX_RegWrite__i,
  input  logic [REG_W-1:0] IDEX_RegDst__i,
  input  logic             EXMEM_MemRead__i,
  input  logic [REG_W-1:0] EXMEM_RegRd__i,
  output logic             PCWrite__o,
  output logic             IFIDWrite__o,
  output logic             IDEXBubble__o,
  output logic             IFIDFlush__o,
  output logic             Stall__o
`ifdef STALL_COUNTER_EN
  , output logic [CNT_W-1:0] StallCnt__o,
  output logic [CNT_W-1:0] FlushCnt__o
`endif
);

  typedef enum logic [1:0] {RUN = 2'b00, HOLD2 = 2'b01, HOLD1 = 2'b10} state_t;

  state_t state;
  logic   dep_ex, dep_mem;
  logic   haz_two, haz_one, hazard;
  logic   held, stall, flush;

  always_comb begin
    dep_ex  = (IDEX_RegDst__i != '0) &&
              ((IDEX_RegDst__i == IFID_RegRs__i) ||
               (IFID_UsesRt__i && (IDEX_RegDst__i == IFID_RegRt__i)));
    dep_mem = (EXMEM_RegRd__i != '0) &&
              ((EXMEM_RegRd__i == IFID_RegRs__i) ||
               (IFID_UsesRt__i && (EXMEM_RegRd__i == IFID_RegRt__i)));
    haz_two = Branch__i && IDEX_MemRead__i && dep_ex;
    haz_one = (IDEX_MemRead__i && dep_ex) ||
              (Branch__i && IDEX_RegWrite__i && !IDEX_MemRead__i && dep_ex) ||
              (Branch__i && EXMEM_MemRead__i && dep_mem);
    hazard  = haz_two || haz_one;
    held    = (state == HOLD1) || (state == HOLD2);
    // Reset overrides everything; a held stall ignores the (stale) inputs entirely.
    stall   = !reset__i && (held || hazard);
    flush   = !reset__i && !held && !hazard && Branch__i && BranchTaken__i;
  end

  assign PCWrite__o    = !stall;
  assign IFIDWrite__o  = !stall;
  assign IDEXBubble__o = stall;
  assign IFIDFlush__o  = flush;
  assign Stall__o      = stall;

  always_ff @(posedge clk__i) begin
    if (reset__i) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= haz_two ? HOLD1 : RUN;
        HOLD2:   state <= HOLD1;
        HOLD1:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge clk__i) begin
    if (reset__i) begin
      StallCnt__o <= '0;
      FlushCnt__o <= '0;
    end else begin
      if (stall && (StallCnt__o != '1)) StallCnt__o <= StallCnt__o + CNT_W'(1);
      if (flush && (FlushCnt__o != '1)) FlushCnt__o <= FlushCnt__o + CNT_W'(1);
    end
  end
`endif

endmodule
